dmem_wait: RTL and testbench
============================

# dmem_wait

Parametrised data memory with programmable wait states, byte-lane write enables and a req/ready handshake, generating the stall the MIPS core needs when the memory is not single-cycle. It sits between the core's data port and the data RAM in the system top, replacing the combinational-read, unconditional-write data memory. Out-of-range or misaligned accesses are flagged instead of silently aliasing.

## Interface
- DATA_W, 32: data word width in bits; multiple of 8.
- ADDR_W, 32: byte address width.
- DEPTH, 64: number of DATA_W-bit words; power of two, 2..4096.
- WAIT, 2: added wait states per access, 0..15.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  access request; held by core until ready.
- we  in  1  1 = store, 0 = load; sampled with req.
- be  in  DATA_W/8  byte-lane write enables; bit i writes data bits [8i+7:8i].
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  store data.
- rdata  out  DATA_W  registered load data.
- ready  out  1  one-cycle completion pulse.
- err  out  1  completion was rejected (misaligned or out of range); valid with ready.
- stall  out  1  combinational: req & ~ready; drives the core's pipeline freeze.

## Operation
- States: IDLE, BUSY, DONE. Wait counter cnt, 4 bits.
- IDLE: req=1 at a rising edge -> accept; latch we, be, addr, wdata; cnt <= WAIT; go BUSY. req=0 -> stay IDLE.
- BUSY: cnt != 0 -> cnt <= cnt-1, stay. cnt == 0 -> perform access on this edge, go DONE.
- DONE: ready=1 for this one cycle; next edge -> IDLE unconditionally. req seen in DONE is not a new request.
- Word index = addr[log2(DEPTH)+1:2] of the latched address.
- Error check on latched address: addr[1:0] != 0, or any addr bit above log2(DEPTH)+1 set. Error -> no array write, rdata unchanged, err=1 during DONE.
- Store: array word written only in lanes with be[i]=1; be=0 is a legal no-op store that still completes. rdata unchanged by stores.
- Load: rdata <= full array word; be ignored.
- rdata holds its value until the next successful load completes.
- Array contents are not reset; simulation initial contents zero.
- Request inputs are read only at acceptance; changes during BUSY have no effect.

## Timing
- Reset (async assert, any state): state=IDLE, cnt=0, ready=0, err=0, rdata=0. An access not yet committed is abandoned and its write never occurs; a write committed on an earlier edge stays.
- Reset release is synchronised by the integrator; the block samples req from the first edge after rst_n rises.
- Acceptance edge = edge E0. Access commits at edge E0+WAIT+1; ready=1 in the cycle after it, from E0+WAIT+1 to E0+WAIT+2.
- WAIT=0: accepted at E0, committed at E0+1, ready in cycle E0+1..E0+2.
- Load latency from req rise to ready = WAIT+2 cycles; throughput one access per WAIT+3 cycles with req held continuously.
- stall=1 from req rise until the ready cycle; stall=0 during the ready cycle so the core advances on the edge ending DONE.
- err and ready assert in the same cycle; err=0 whenever ready=0.

## Test plan
- Reset: drive rst_n=0 mid-BUSY of a store to word 3 -> ready=0, err=0, rdata=0 immediately; later load of word 3 returns prior value (0).
- WAIT=2 store 0xDEADBEEF to addr 0x10, be=4'hF, then load 0x10 -> ready exactly 4 cycles after each req rise; rdata=0xDEADBEEF; stall high for 4 cycles.
- Byte lanes: store 0x11223344 be=4'hF to 0x8, then store 0xAABBCCDD be=4'b0101, then load -> 0x11BB33DD.
- Errors: load at 0x6 (misaligned) and at 0x100 with DEPTH=64 -> ready with err=1, rdata unchanged, no write; store to 0x100 does not alias word 0.
- WAIT=0 back-to-back: req held high for three loads of 0x0, 0x4, 0x8 -> ready pulses 3 cycles apart, correct rdata each, no double acceptance.
- Input change during BUSY: alter addr/wdata after acceptance -> access uses the latched values.

Source files
------------

// File: rtl/dmem_wait_if.sv
// Data-memory port bundle between the core data port and dmem_wait.
// Core side drives the request; memory side returns data, completion and stall.
interface dmem_wait_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;
    logic                  err;
    logic                  stall;

    modport master (
        output req, we, be, addr, wdata,
        input  rdata, ready, err, stall
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output rdata, ready, err, stall
    );
endinterface

// File: rtl/dmem_wait.sv
// Data memory with programmable wait states, byte-lane stores and a
// req/ready handshake; flags misaligned or out-of-range accesses.
module dmem_wait #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64,
    parameter int WAIT   = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    dmem_wait_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_C = 4'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [NB-1:0]       r_be;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ready;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [IDX_W-1:0]    w_idx;
    logic                w_err;
    logic                w_commit;

    assign w_idx    = r_addr[IDX_W+1:2];
    assign w_err    = (r_addr[1:0] != 2'b00)
                   || ((r_addr >> (IDX_W + 2)) != '0);
    assign w_commit = (r_state == S_BUSY) && (r_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_be    <= bus.be;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_cnt   <= WAIT_C;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                        r_err   <= w_err;
                        if (!r_we && !w_err)
                            r_rdata <= r_mem[w_idx];
                    end
                end
                S_DONE: begin
                    // a req still high here belongs to the finished access
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Array is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (w_commit && r_we && !w_err) begin
            for (int i = 0; i < NB; i++) begin
                if (r_be[i])
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ready = r_ready;
    assign bus.err   = r_err;
    assign bus.stall = bus.req & ~r_ready;
endmodule

// File: tb/tb_dmem_wait.sv
// Directed bench for dmem_wait: WAIT=2 instance for most scenarios,
// WAIT=0 instance for back-to-back throughput.
module tb_dmem_wait;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dmem_wait_if #(.DATA_W(32), .ADDR_W(32)) bus ();
    dmem_wait_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();

    dmem_wait #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    dmem_wait #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete access on the WAIT=2 port; reports latency and flags
    task automatic acc(
        input  logic        w,
        input  logic [3:0]  b,
        input  logic [31:0] a,
        input  logic [31:0] d,
        output int          cyc,
        output int          stl,
        output logic [31:0] rd,
        output logic        e,
        output logic        st,
        output logic        aft
    );
        @(negedge clk);
        bus.req = 1'b1;
        bus.we = w;
        bus.be = b;
        bus.addr = a;
        bus.wdata = d;
        #1;
        cyc = 0;
        stl = 0;
        while (!bus.ready && cyc < 50) begin
            if (bus.stall) stl++;
            @(negedge clk);
            cyc++;
        end
        rd = bus.rdata;
        e = bus.err;
        st = bus.stall;
        bus.req = 1'b0;
        @(negedge clk);
        aft = bus.ready | bus.err;
    endtask

    task automatic test_reset();
        int cyc, stl;
        logic [31:0] rd;
        logic e, st, aft;
        checks++;
        if (bus.ready !== 1'b0 || bus.err !== 1'b0
            || bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state rdy=%b err=%b rdata=%h exp 0 0 0",
                     bus.ready, bus.err, bus.rdata);
        end
        acc(1, 4'hF, 32'hC, 32'h0, cyc, stl, rd, e, st, aft);
        acc(1, 4'hF, 32'h20, 32'hCAFEF00D, cyc, stl, rd, e, st, aft);
        acc(0, 4'hF, 32'h20, 32'h0, cyc, stl, rd, e, st, aft);
        checks++;
        if (rd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL reset_preload got %h exp cafef00d", rd);
        end
        @(negedge clk);
        bus.req = 1'b1;
        bus.we = 1'b1;
        bus.be = 4'hF;
        bus.addr = 32'hC;
        bus.wdata = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ready !== 1'b0 || bus.err !== 1'b0
            || bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_busy rdy=%b err=%b rdata=%h exp 0 0 0",
                     bus.ready, bus.err, bus.rdata);
        end
        bus.req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acc(0, 4'hF, 32'hC, 32'h0, cyc, stl, rd, e, st, aft);
        checks++;
        if (rd !== 32'h0 || e !== 1'b0 || cyc != 4) begin
            errors++;
            $display("FAIL reset_abandon rdata=%h err=%b cyc=%0d exp 0 0 4",
                     rd, e, cyc);
        end
    endtask

    task automatic test_basic();
        int cyc, stl;
        logic [31:0] rd;
        logic e, st, aft;
        acc(1, 4'hF, 32'h10, 32'hDEADBEEF, cyc, stl, rd, e, st, aft);
        checks++;
        if (cyc != 4 || stl != 4 || st !== 1'b0 || e !== 1'b0
            || aft !== 1'b0) begin
            errors++;
            $display("FAIL store_timing cyc=%0d stall=%0d st=%b e=%b aft=%b exp 4 4 0 0 0",
                     cyc, stl, st, e, aft);
        end
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL store_rdata got %h exp 0", rd);
        end
        acc(0, 4'hF, 32'h10, 32'h0, cyc, stl, rd, e, st, aft);
        checks++;
        if (cyc != 4 || stl != 4 || st !== 1'b0 || aft !== 1'b0) begin
            errors++;
            $display("FAIL load_timing cyc=%0d stall=%0d st=%b aft=%b exp 4 4 0 0",
                     cyc, stl, st, aft);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL load_data got %h err=%b exp deadbeef 0", rd, e);
        end
    endtask

    task automatic test_byte_lanes();
        int cyc, stl;
        logic [31:0] rd;
        logic e, st, aft;
        acc(1, 4'hF, 32'h8, 32'h11223344, cyc, stl, rd, e, st, aft);
        acc(1, 4'b0101, 32'h8, 32'hAABBCCDD, cyc, stl, rd, e, st, aft);
        acc(0, 4'h0, 32'h8, 32'h0, cyc, stl, rd, e, st, aft);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL byte_lanes got %h exp 11bb33dd", rd);
        end
        acc(1, 4'h0, 32'h8, 32'hFFFFFFFF, cyc, stl, rd, e, st, aft);
        checks++;
        if (cyc != 4 || e !== 1'b0 || rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL be0_store cyc=%0d err=%b rdata=%h exp 4 0 11bb33dd",
                     cyc, e, rd);
        end
        acc(0, 4'hF, 32'h8, 32'h0, cyc, stl, rd, e, st, aft);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL be0_noop got %h exp 11bb33dd", rd);
        end
    endtask

    task automatic test_errors();
        int cyc, stl;
        logic [31:0] rd;
        logic e, st, aft;
        acc(1, 4'hF, 32'h0, 32'h55AA55AA, cyc, stl, rd, e, st, aft);
        acc(0, 4'hF, 32'h0, 32'h0, cyc, stl, rd, e, st, aft);
        acc(0, 4'hF, 32'h6, 32'h0, cyc, stl, rd, e, st, aft);
        checks++;
        if (e !== 1'b1 || rd !== 32'h55AA55AA || cyc != 4
            || aft !== 1'b0) begin
            errors++;
            $display("FAIL err_misalign err=%b rdata=%h cyc=%0d aft=%b exp 1 55aa55aa 4 0",
                     e, rd, cyc, aft);
        end
        acc(0, 4'hF, 32'h100, 32'h0, cyc, stl, rd, e, st, aft);
        checks++;
        if (e !== 1'b1 || rd !== 32'h55AA55AA) begin
            errors++;
            $display("FAIL err_range err=%b rdata=%h exp 1 55aa55aa", e, rd);
        end
        acc(1, 4'hF, 32'h100, 32'h99999999, cyc, stl, rd, e, st, aft);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL err_store_range err=%b exp 1", e);
        end
        acc(1, 4'hF, 32'h2, 32'h77777777, cyc, stl, rd, e, st, aft);
        acc(0, 4'hF, 32'h0, 32'h0, cyc, stl, rd, e, st, aft);
        checks++;
        if (rd !== 32'h55AA55AA || e !== 1'b0) begin
            errors++;
            $display("FAIL err_no_alias got %h err=%b exp 55aa55aa 0", rd, e);
        end
    endtask

    task automatic test_busy_change();
        int cyc, stl, n;
        logic [31:0] rd;
        logic e, st, aft;
        acc(1, 4'hF, 32'h18, 32'h01010101, cyc, stl, rd, e, st, aft);
        @(negedge clk);
        bus.req = 1'b1;
        bus.we = 1'b1;
        bus.be = 4'hF;
        bus.addr = 32'h14;
        bus.wdata = 32'h0BADF00D;
        @(negedge clk);
        bus.we = 1'b0;
        bus.be = 4'h0;
        bus.addr = 32'h18;
        bus.wdata = 32'hFFFFFFFF;
        n = 0;
        while (!bus.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.req = 1'b0;
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL busy_latency got %0d exp 3", n);
        end
        acc(0, 4'hF, 32'h14, 32'h0, cyc, stl, rd, e, st, aft);
        checks++;
        if (rd !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL busy_latched got %h exp 0badf00d", rd);
        end
        acc(0, 4'hF, 32'h18, 32'h0, cyc, stl, rd, e, st, aft);
        checks++;
        if (rd !== 32'h01010101) begin
            errors++;
            $display("FAIL busy_untouched got %h exp 01010101", rd);
        end
    endtask

    task automatic test_back_to_back();
        int k, n, last, extra;
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            bus0.req = 1'b1;
            bus0.we = (p == 0);
            bus0.be = 4'hF;
            bus0.addr = 32'h0;
            bus0.wdata = 32'hA0;
            k = 0;
            n = 0;
            last = 0;
            while (k < 3 && n < 60) begin
                @(negedge clk);
                n++;
                if (bus0.ready) begin
                    if (k > 0) begin
                        checks++;
                        if (n - last != 3) begin
                            errors++;
                            $display("FAIL b2b_gap pass=%0d got %0d exp 3",
                                     p, n - last);
                        end
                    end
                    if (p == 1) begin
                        checks++;
                        if (bus0.rdata !== 32'hA0 + 32'(k)) begin
                            errors++;
                            $display("FAIL b2b_rdata k=%0d got %h exp %h",
                                     k, bus0.rdata, 32'hA0 + 32'(k));
                        end
                    end
                    last = n;
                    k++;
                    bus0.addr = 32'(4 * k);
                    bus0.wdata = 32'hA0 + 32'(k);
                end
            end
            bus0.req = 1'b0;
            checks++;
            if (k != 3) begin
                errors++;
                $display("FAIL b2b_count pass=%0d got %0d exp 3", p, k);
            end
            extra = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (bus0.ready) extra++;
            end
            checks++;
            if (extra != 0) begin
                errors++;
                $display("FAIL b2b_extra pass=%0d got %0d exp 0", p, extra);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.req = 1'b0;
        bus.we = 1'b0;
        bus.be = 4'h0;
        bus.addr = 32'h0;
        bus.wdata = 32'h0;
        bus0.req = 1'b0;
        bus0.we = 1'b0;
        bus0.be = 4'h0;
        bus0.addr = 32'h0;
        bus0.wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_byte_lanes();
        test_errors();
        test_busy_change();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
